// File: rtl/mem_responder.sv
// Word-addressed memory responder: one outstanding request, fixed WAIT latency,
// single-cycle response strobe with error flag for misaligned/out-of-range accesses.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        ready,
  output logic [31:0] ReadData,
  output logic        rvalid,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [31:0]   adr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic          bad;
  logic [AW-1:0] idx;

  always_comb begin
    accept = (state == IDLE) && req;
    access = (state == WAIT) && (cnt == '0);
    idx    = adr_q[AW+1:2];
    bad    = (adr_q[1:0] != 2'b00) || (adr_q[31:AW+2] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == IDLE);
    rvalid = (state == RESP);
    err    = (state == RESP) && err_q;
  end

  // Request fields are captured once at acceptance so later input activity cannot disturb the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      ReadData <= '0;
    end else begin
      if (accept) begin
        adr_q   <= Adr;
        wdata_q <= WriteData;
        we_q    <= we;
        cnt     <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        err_q <= bad;
        if (bad)        ReadData <= '0;
        else if (!we_q) ReadData <= mem[idx];
      end
    end
  end

  // Storage is deliberately not reset; reset forces IDLE, so a pending write never reaches here.
  always_ff @(posedge clk) begin
    if (access && we_q && !bad) mem[idx] <= wdata_q;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
- REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored; SHALL be a power of two, at least 4.
- REQ-002 Parameter LATENCY, default 2, number of cycles spent in WAIT per request; SHALL be at least 1.
- REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004 reset  input  1  asynchronous, active-high reset.
- REQ-005 req  input  1  request strobe from the processor.
- REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
- REQ-007 Adr  input  32  byte address; sampled with req.
- REQ-008 WriteData  input  32  write data; sampled with req.
- REQ-009 ready  output  1  responder can accept a request this cycle.
- REQ-010 ReadData  output  32  registered read data.
- REQ-011 rvalid  output  1  response strobe, one cycle per accepted request.
- REQ-012 err  output  1  response error flag; meaningful only while rvalid=1.

Function
- REQ-013 The FSM SHALL have the states IDLE, WAIT and RESP; ready SHALL be 1 only in IDLE.
- REQ-014 A request SHALL be accepted at a rising edge where state=IDLE and req=1; at that edge Adr, WriteData and we SHALL be latched, a counter SHALL load LATENCY-1, and the state SHALL become WAIT.
- REQ-015 req SHALL be ignored in WAIT and RESP; input changes after acceptance SHALL NOT affect the pending access.
- REQ-016 In WAIT, an edge with counter=0 SHALL move the state to RESP; otherwise the edge SHALL decrement the counter.
- REQ-017 The memory access (write commit or read capture into ReadData) SHALL occur at the WAIT->RESP edge.
- REQ-018 RESP SHALL last exactly one cycle, with rvalid=1; the next edge SHALL return to IDLE.
- REQ-019 If acceptance is edge 0, rvalid SHALL be high exactly in the cycle after edge LATENCY, and ready SHALL return to 1 after edge LATENCY+1.
- REQ-020 Maximum throughput SHALL be one request per LATENCY+2 cycles.
- REQ-021 Word index SHALL be Adr[31:2]; the request SHALL be an error if Adr[1:0]!=0 or the index is at least DEPTH_WORDS.
- REQ-022 On an error the write SHALL be suppressed, ReadData SHALL be 0x00000000, and err SHALL be 1 in RESP.
- REQ-023 On a successful write, err SHALL be 0 and ReadData SHALL hold its previous value.
- REQ-024 On a successful read, ReadData SHALL be the stored word.
- REQ-025 A read issued after a completed write to the same index SHALL return the new data.
- REQ-026 Outside RESP, rvalid and err SHALL be 0; ReadData SHALL hold until the next read or error response.

Reset
- REQ-027 reset=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, rvalid=0, err=0 and ReadData=0x00000000.
- REQ-028 A request in WAIT when reset asserts SHALL be discarded: a pending write SHALL NOT commit, and no rvalid SHALL follow.
- REQ-029 Memory array contents SHALL NOT be cleared by reset; power-up contents are undefined.
- REQ-030 ready SHALL be 1 during and after reset.
- REQ-031 The first request SHALL be accepted at the first rising edge with reset=0 and req=1.

Verification (LATENCY=2, DEPTH_WORDS=64)
- REQ-032 Write, then read: write 0x00000010 with data 0xDEADBEEF, then read 0x00000010 -> both responses have err=0; the read returns ReadData=0xDEADBEEF.
- REQ-033 Latency and ready timing: read accepted at edge 0 -> ready=0 after edges 0 to 2; rvalid=1 only in the cycle after edge 2; ready=1 after edge 3.
- REQ-034 Misaligned accesses: read 0x00000012 -> err=1, ReadData=0. Write 0x00000022 with data 0x1 -> err=1. A later read of 0x00000020 -> returns its prior value.
- REQ-035 Out of range: write 0x00000100 (index 64) with data 0x5 -> err=1. A later read of 0x00000100 -> err=1, ReadData=0.
- REQ-036 Reset mid-operation: write 0x00000004 with data 0xAAAA5555, then assert reset in WAIT -> outputs zero at once, no rvalid. After release, read 0x00000004 -> returns the pre-reset contents.
- REQ-037 Continuous req: req held at 1 while Adr changes each cycle -> acceptances exactly 4 edges apart; each response reflects the Adr latched at its own acceptance.
